conv_window_scheduler: RTL and testbench

Sequencing controller for the convolution sub-top: the BRAMs, the 16-lane PE cluster and the address generator.
- Takes a layer start and configuration, then gates the address generator's ready (cal_start).
- Counts completed windows and issues per-window PE_finish / PE_reset pulses.
- Presents each finished 16-filter output pixel to a downstream writer through a valid/ready handshake.
- Stop-and-go per window: computation pauses while a result waits for acceptance.

---
 rtl/conv_sched_pkg.sv | 30 +++
 rtl/conv_sched_counter.sv | 36 +++
 rtl/conv_window_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types, constants and helpers for the convolution window scheduler.
package conv_sched_pkg;

    localparam int PE_NUM    = 32'sd16;
    localparam int PIPE_LAT  = 32'sd2;
    localparam int PRIME_LAT = 32'sd1;
    localparam int CNT_W     = 32'sd16;
    localparam int LAT_W     = 32'sd4;

    // Latency-counter terminal values; PIPE_PRE_LAST marks the DRAIN cycle before pe_finish.
    localparam logic [LAT_W-1:0] PRIME_LAST    = LAT_W'(PRIME_LAT - 32'sd1);
    localparam logic [LAT_W-1:0] PIPE_LAST     = LAT_W'(PIPE_LAT - 32'sd1);
    localparam logic [LAT_W-1:0] PIPE_PRE_LAST = LAT_W'(PIPE_LAT - 32'sd2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } sched_state_t;

    function automatic logic [7:0] ceil_div16(input logic [7:0] chans);
        logic [8:0] sum_s;
        sum_s = {1'b0, chans} + 9'd15;
        return {3'b000, sum_s[8:4]};
    endfunction

endpackage

// File: rtl/conv_sched_counter.sv
// Generic up-counter with clear/load/increment and a terminal-count flag.
module conv_sched_counter #(
    parameter int W = 32'sd8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         last
);

    localparam logic [W-1:0] CNT_ONE  = W'(1'b1);
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    // Count register: clear beats load, load beats increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= CNT_ZERO;
        end else if (clear) begin
            count <= CNT_ZERO;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

    assign last = (count == limit);

endmodule

// File: rtl/conv_window_scheduler.sv
// Layer sequencer: primes BRAMs, gates the address generator, drains the PE pipeline
// and hands each finished 16-filter pixel to the writer with stop-and-go backpressure.
module conv_window_scheduler
    import conv_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_ofm_w,
    input  logic [7:0]        cfg_ofm_c,
    input  logic              done_window,
    output logic              cal_start,
    output logic [PE_NUM-1:0] pe_finish,
    output logic [PE_NUM-1:0] pe_reset,
    output logic              ofm_valid,
    input  logic              ofm_ready,
    output logic [CNT_W-1:0]  ofm_pixel_idx,
    output logic [7:0]        ofm_group_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [PE_NUM-1:0] PE_ALL   = {PE_NUM{1'b1}};
    localparam logic [PE_NUM-1:0] PE_NONE  = {PE_NUM{1'b0}};
    localparam logic [CNT_W-1:0]  PIX_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  PIX_ZERO = {CNT_W{1'b0}};

    sched_state_t      state_r;
    logic [CNT_W-1:0]  pix_limit_r;
    logic [7:0]        grp_limit_r;

    logic [CNT_W-1:0]  total_pix_s;
    logic [7:0]        groups_s;
    logic              accept_s;
    logic              pix_clear_s;
    logic              pix_inc_s;
    logic              pix_last_s;
    logic              grp_clear_s;
    logic              grp_inc_s;
    logic              grp_last_s;
    logic              lat_clear_s;
    logic              lat_inc_s;
    logic              lat_last_s;
    logic [LAT_W-1:0]  lat_limit_s;
    logic [LAT_W-1:0]  lat_cnt_s;

    // Layer geometry from the live cfg inputs and counter sequencing controls.
    always_comb begin
        total_pix_s = {8'h00, cfg_ofm_w} * {8'h00, cfg_ofm_w};
        groups_s    = ceil_div16(cfg_ofm_c);
        accept_s    = (state_r == WRITE) && ofm_valid && ofm_ready;

        pix_clear_s = abort || (state_r == DONE) || ((state_r == IDLE) && start)
                      || (accept_s && pix_last_s && !grp_last_s);
        pix_inc_s   = accept_s && !pix_last_s;
        grp_clear_s = abort || (state_r == DONE) || ((state_r == IDLE) && start);
        grp_inc_s   = accept_s && pix_last_s && !grp_last_s;

        // Latency counter idles at zero so it is ready on PRIME/DRAIN entry.
        lat_clear_s = abort || !((state_r == PRIME) || (state_r == DRAIN));
        lat_inc_s   = ((state_r == PRIME) || (state_r == DRAIN)) && !lat_last_s;
        if (state_r == PRIME) begin
            lat_limit_s = PRIME_LAST;
        end else begin
            lat_limit_s = PIPE_LAST;
        end
    end

    conv_sched_counter #(.W(CNT_W)) u_pix_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (pix_clear_s),
        .load     (1'b0),
        .load_val (PIX_ZERO),
        .inc      (pix_inc_s),
        .limit    (pix_limit_r),
        .count    (ofm_pixel_idx),
        .last     (pix_last_s)
    );

    conv_sched_counter #(.W(8)) u_grp_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (grp_clear_s),
        .load     (1'b0),
        .load_val (8'h00),
        .inc      (grp_inc_s),
        .limit    (grp_limit_r),
        .count    (ofm_group_idx),
        .last     (grp_last_s)
    );

    conv_sched_counter #(.W(LAT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (lat_clear_s),
        .load     (1'b0),
        .load_val ({LAT_W{1'b0}}),
        .inc      (lat_inc_s),
        .limit    (lat_limit_s),
        .count    (lat_cnt_s),
        .last     (lat_last_s)
    );

    // Sequencing FSM; every output pulse and level is registered here.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_r     <= IDLE;
            pix_limit_r <= PIX_ZERO;
            grp_limit_r <= 8'h00;
            cal_start   <= 1'b0;
            pe_finish   <= PE_NONE;
            pe_reset    <= PE_NONE;
            ofm_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            pe_reset  <= PE_NONE;
            pe_finish <= PE_NONE;
            done      <= 1'b0;
            if (done_window && (state_r != RUN)) begin
                err <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        pix_limit_r <= total_pix_s - PIX_ONE;
                        grp_limit_r <= groups_s - 8'd1;
                        err         <= done_window;
                        busy        <= 1'b1;
                        if ((total_pix_s == PIX_ZERO) || (groups_s == 8'd0)) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= PRIME;
                            pe_reset <= PE_ALL;
                        end
                    end
                end
                PRIME: begin
                    if (lat_last_s) begin
                        state_r   <= RUN;
                        cal_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (done_window) begin
                        state_r   <= DRAIN;
                        cal_start <= 1'b0;
                        if (PIPE_LAST == {LAT_W{1'b0}}) begin
                            pe_finish <= PE_ALL;
                        end
                    end
                end
                DRAIN: begin
                    if (lat_last_s) begin
                        state_r   <= WRITE;
                        ofm_valid <= 1'b1;
                    end else if (lat_cnt_s == PIPE_PRE_LAST) begin
                        pe_finish <= PE_ALL;
                    end
                end
                WRITE: begin
                    if (accept_s) begin
                        ofm_valid <= 1'b0;
                        if (pix_last_s && grp_last_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= PRIME;
                            pe_reset <= PE_ALL;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    cal_start <= 1'b0;
                    ofm_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed + randomized bench for conv_window_scheduler; expectations come from the
// layer rules (pixels x groups handshake order, fixed PRIME/DRAIN latencies).
module tb_conv_window_scheduler;
    import conv_sched_pkg::*;

    localparam logic [63:0] LANES = {{(64-PE_NUM){1'b0}}, {PE_NUM{1'b1}}};

    logic              clk = 1'b0;
    logic              reset, start, abort, done_window, ofm_ready;
    logic [7:0]        cfg_ofm_w, cfg_ofm_c;
    logic              cal_start, ofm_valid, busy, done, err;
    logic [PE_NUM-1:0] pe_finish, pe_reset;
    logic [CNT_W-1:0]  ofm_pixel_idx;
    logic [7:0]        ofm_group_idx;

    int errors = 0;
    int checks = 0;

    conv_window_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cfg_ofm_w     (cfg_ofm_w),
        .cfg_ofm_c     (cfg_ofm_c),
        .done_window   (done_window),
        .cal_start     (cal_start),
        .pe_finish     (pe_finish),
        .pe_reset      (pe_reset),
        .ofm_valid     (ofm_valid),
        .ofm_ready     (ofm_ready),
        .ofm_pixel_idx (ofm_pixel_idx),
        .ofm_group_idx (ofm_group_idx),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {3'b000, cal_start, pe_finish, pe_reset, ofm_valid,
                ofm_pixel_idx, ofm_group_idx, busy, done, err};
    endfunction

    // One layer: every (group, pixel) pair in order, with the fixed window timeline.
    task automatic run_layer(input int w, input int c, input int run_len_fix,
                             input int stall_fix, input int stop_pix,
                             input bit use_reset, input bit inject_err);
        int total;
        int groups;
        int rl;
        int stall;
        bit err_exp;
        total   = w * w;
        groups  = (c + 15) / 16;
        err_exp = 1'b0;
        cfg_ofm_w = 8'(w);
        cfg_ofm_c = 8'(c);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cfg_ofm_w = 8'($urandom);
        cfg_ofm_c = 8'($urandom);
        check("busy_after_start", busy, 1);
        check("err_cleared_by_start", err, 0);
        if (total == 0 || groups == 0) begin
            check("zero_cfg_done", done, 1);
            check("zero_cfg_quiet", {cal_start, pe_finish, pe_reset, ofm_valid}, 0);
            cycle();
            check("zero_cfg_idle", {cal_start, pe_finish, ofm_valid, busy, done}, 0);
            return;
        end
        for (int g = 0; g < groups; g++) begin
            for (int p = 0; p < total; p++) begin
                check("pe_reset_on_prime", pe_reset, LANES);
                check("prime_cal_low", cal_start, 0);
                cycle();
                check("pe_reset_single", pe_reset, 0);
                check("run_cal_high", cal_start, 1);
                if (g == 0 && p == stop_pix) begin
                    if (use_reset) reset = 1'b1;
                    else abort = 1'b1;
                    cycle();
                    reset = 1'b0;
                    abort = 1'b0;
                    check(use_reset ? "reset_all_zero" : "abort_all_zero", all_outputs(), 0);
                    repeat (4) begin
                        cycle();
                        check("no_done_after_abort", {done, busy}, 0);
                    end
                    return;
                end
                rl = (run_len_fix > 0) ? run_len_fix : int'($urandom_range(1, 6));
                for (int i = 1; i < rl; i++) begin
                    start     = 1'($urandom);
                    ofm_ready = 1'($urandom);
                    cfg_ofm_w = 8'($urandom);
                    cfg_ofm_c = 8'($urandom);
                    cycle();
                    check("run_cal_hold", cal_start, 1);
                end
                start = 1'b0;
                done_window = 1'b1;
                cycle();
                done_window = 1'b0;
                check("drain_cal_low", cal_start, 0);
                check("drain_no_finish_yet", pe_finish, 0);
                ofm_ready = 1'($urandom);
                cycle();
                check("pe_finish_at_T2", pe_finish, LANES);
                check("valid_not_before_T3", ofm_valid, 0);
                ofm_ready = 1'($urandom);
                cycle();
                check("valid_at_T3", ofm_valid, 1);
                check("pe_finish_single", pe_finish, 0);
                check("pixel_idx", ofm_pixel_idx, 64'(p));
                check("group_idx", ofm_group_idx, 64'(g));
                stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
                ofm_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    done_window = inject_err && (s == 0);
                    cycle();
                    if (done_window) err_exp = 1'b1;
                    done_window = 1'b0;
                    check("stall_hold", {ofm_valid, cal_start, ofm_pixel_idx, ofm_group_idx},
                          {1'b1, 1'b0, 16'(p), 8'(g)});
                    check("err_flag_stall", err, 64'(err_exp));
                end
                ofm_ready = 1'b1;
                cycle();
                ofm_ready = 1'b0;
                check("valid_drop_after_accept", ofm_valid, 0);
                if (g == groups - 1 && p == total - 1) begin
                    check("done_pulse", {done, busy, err}, {1'b1, 1'b1, err_exp});
                    cycle();
                    check("done_then_idle", {done, busy, cal_start}, 0);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        done_window = 1'b0;
        ofm_ready = 1'b0;
        cfg_ofm_w = 8'd0;
        cfg_ofm_c = 8'd0;
        repeat (2) cycle();
        reset = 1'b0;
        check("reset_state", all_outputs(), 0);

        // Stray done_window while idle flags err, which stays set.
        done_window = 1'b1;
        cycle();
        done_window = 1'b0;
        check("err_stray_idle", err, 1);
        cycle();
        check("err_sticky_idle", {err, busy}, {1'b1, 1'b0});

        run_layer(2, 32, 9, 0, -1, 1'b0, 1'b0);
        run_layer(1, 16, 3, 5, -1, 1'b0, 1'b0);
        run_layer(2, 0, 0, 0, -1, 1'b0, 1'b0);
        run_layer(0, 16, 0, 0, -1, 1'b0, 1'b0);
        run_layer(2, 16, 4, 0, 2, 1'b0, 1'b0);
        run_layer(1, 16, 2, 0, -1, 1'b0, 1'b0);
        run_layer(2, 16, 4, 0, 2, 1'b1, 1'b0);
        run_layer(1, 16, 2, 0, -1, 1'b0, 1'b0);
        run_layer(1, 20, 2, 3, -1, 1'b0, 1'b1);
        check("err_sticky_after_layer", err, 1);

        for (int k = 0; k < 5; k++) begin
            run_layer(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
                      0, -1, -1, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
